score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Bank/credit stage directly downstream of the reel-stop sequencer.
- Watches the sequencer's `spinning` and `to_score` levels and charges the bet when a spin starts.
- When all four reels have stopped, it classifies the four latched reel digits and adds the payout to the credit score.
- Drives `score` and `is_broke` back to the sequencer and the 7-segment display path.

Parameters:
- START_SCORE, 100: credit loaded at reset and on new_game.
- BET, 10: cost of one spin.
- MAX_SCORE, 9999: saturation ceiling (4-digit display).
- PAY_PAIR, 20: exactly one matching pair.
- PAY_TWO_PAIR, 50: two distinct pairs.
- PAY_THREE, 100: three of a kind.
- PAY_FOUR, 500: four of a kind, not 7s.
- PAY_JACKPOT, 1000: four 7s.

Ports:
- clk, input, 1: system clock (100 MHz).
- rst_n, input, 1: asynchronous active-low reset.
- spinning, input, 1: level from reel-stop sequencer; asynchronous to clk (2 Hz domain).
- to_score, input, 1: level from reel-stop sequencer, high once all reels have stopped; asynchronous.
- new_game, input, 1: one-clk pulse (debounced button), restarts the bank.
- reel1..reel4, input, 4 each: displayed reel digits, 0-9; stable while to_score is high.
- score, output, 14: current credit, 0..MAX_SCORE.
- is_broke, output, 1: high when score < BET.
- last_win, output, 14: payout of the most recent evaluated spin.
- win_valid, output, 1: one-clk pulse when last_win/score are updated by a payout.
- jackpot, output, 1: sticky; set by a jackpot payout, cleared by new_game or the next bet.

Behaviour:
- Reset (rst_n low, async): score = START_SCORE, last_win = 0, win_valid = 0, jackpot = 0, is_broke = (START_SCORE < BET), FSM = IDLE, synchronizer flops = 0.
- Synchronizers:
  - spinning and to_score each pass through a 2-flop synchronizer, then a third flop for edge detect.
  - rise = sync2 & ~sync3.
  - A rise is acted on at the 3rd rising clk edge after the input goes high.
- is_broke is combinational from the score register.
- FSM states: IDLE, SPIN, EVAL, PAY.
- IDLE:
  - spin_rise with score >= BET: score -= BET, jackpot = 0, go to SPIN.
  - spin_rise with score < BET: ignored, stay IDLE, score unchanged.
  - to_score_rise in IDLE: ignored (no bet was taken).
- SPIN:
  - to_score_rise: capture reel1..4 into internal registers, go to EVAL.
  - A further spin_rise is ignored.
- EVAL (1 cycle):
  - m = number of equal pairs among the 6 pairs (r1r2, r1r3, r1r4, r2r3, r2r4, r3r4), computed from the captured digits.
  - Payout: m=6 → PAY_JACKPOT if the digit is 7, else PAY_FOUR; m=3 → PAY_THREE; m=2 → PAY_TWO_PAIR; m=1 → PAY_PAIR; m=0 → 0.
  - Go to PAY.
- PAY (1 cycle):
  - score = min(score + payout, MAX_SCORE), using a 15-bit intermediate add.
  - last_win = payout, including 0.
  - win_valid = 1 for this cycle only.
  - jackpot = 1 if the payout was a jackpot.
  - Go to IDLE.
- Latency: score updates at the 4th clk edge after to_score rises (3 sync/detect edges + EVAL).
- new_game pulse:
  - Highest priority below reset, in any state.
  - score = START_SCORE, last_win = 0, jackpot = 0, win_valid = 0, FSM = IDLE; a pending evaluation is discarded.
- Boundary conditions:
  - score == BET exactly: bet accepted, score becomes 0, is_broke = 1 until a payout.
  - Saturation at MAX_SCORE is silent; last_win still reports the full payout.
  - spinning and to_score rising in the same cycle while in IDLE: bet is taken, to_score_rise is ignored (the spin is scored on its own to_score edge).
  - Reset asserted mid-EVAL/PAY: no payout is applied.

Test Plan:
- Reset → score=100, is_broke=0, last_win=0, win_valid=0; spinning rise → score=90 three edges later.
- Spin from 100 with reels 3,5,3,8 → score 90 then 110, last_win=20, win_valid pulses exactly 1 clk, 4 edges after to_score rises.
- Reels 2,2,6,6 → +50; 4,4,4,1 → +100; 9,9,9,9 → +500, jackpot=0; 7,7,7,7 → +1000, jackpot=1, then cleared by the next bet; 0,1,2,3 → last_win=0, win_valid still pulses.
- Score 10: spin → 0, is_broke=1. A further spinning rise at score 0 → score stays 0, no state change, and a following to_score rise produces no win_valid.
- Score 9500, reels 7,7,7,7: bet → 9490, payout → score saturates at 9999, last_win=1000.
- new_game pulse while in SPIN → score=100, jackpot=0, FSM IDLE, and the subsequent to_score rise produces no win_valid. rst_n asserted mid-PAY → all outputs return to reset values immediately.

Source files
------------

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Brief    : Credit bank for the slot machine. Charges the bet on the start
//             of a spin, classifies the four stopped reel digits and adds the
//             payout to a saturating 4-digit credit score.
//  Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter int unsigned START_SCORE  = 100,
  parameter int unsigned BET          = 10,
  parameter int unsigned MAX_SCORE    = 9999,
  parameter int unsigned PAY_PAIR     = 20,
  parameter int unsigned PAY_TWO_PAIR = 50,
  parameter int unsigned PAY_THREE    = 100,
  parameter int unsigned PAY_FOUR     = 500,
  parameter int unsigned PAY_JACKPOT  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spinning,
  input  logic        to_score,
  input  logic        new_game,
  input  logic [3:0]  reel1,
  input  logic [3:0]  reel2,
  input  logic [3:0]  reel3,
  input  logic [3:0]  reel4,
  output logic [13:0] score,
  output logic        is_broke,
  output logic [13:0] last_win,
  output logic        win_valid,
  output logic        jackpot
);

  localparam logic [13:0] c_start_score  = 14'(START_SCORE);
  localparam logic [13:0] c_bet          = 14'(BET);
  localparam logic [14:0] c_max_score    = 15'(MAX_SCORE);
  localparam logic [13:0] c_pay_pair     = 14'(PAY_PAIR);
  localparam logic [13:0] c_pay_two_pair = 14'(PAY_TWO_PAIR);
  localparam logic [13:0] c_pay_three    = 14'(PAY_THREE);
  localparam logic [13:0] c_pay_four     = 14'(PAY_FOUR);
  localparam logic [13:0] c_pay_jackpot  = 14'(PAY_JACKPOT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SPIN = 2'd1,
    S_EVAL = 2'd2,
    S_PAY  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_spin_sync;
  logic [2:0]  r_to_sync;
  logic        w_spin_rise;
  logic        w_to_rise;

  logic [3:0]  r_cap1;
  logic [3:0]  r_cap2;
  logic [3:0]  r_cap3;
  logic [3:0]  r_cap4;

  logic [13:0] r_score;
  logic [13:0] r_last_win;
  logic        r_win_valid;
  logic        r_jackpot;

  logic [2:0]  w_match_cnt;
  logic        w_is_jackpot;
  logic [13:0] w_payout;
  logic [14:0] w_sum;
  logic [13:0] w_new_score;

  // Two-flop synchronizers plus one edge-detect stage for the 2 Hz levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spin_sync <= 3'b000;
      r_to_sync   <= 3'b000;
    end else begin
      r_spin_sync <= {r_spin_sync[1:0], spinning};
      r_to_sync   <= {r_to_sync[1:0], to_score};
    end
  end

  assign w_spin_rise = r_spin_sync[1] & ~r_spin_sync[2];
  assign w_to_rise   = r_to_sync[1]   & ~r_to_sync[2];

  // Count equal digit pairs among the six reel pairings and map to a payout
  always_comb begin
    w_match_cnt  = {2'b00, (r_cap1 == r_cap2)} + {2'b00, (r_cap1 == r_cap3)}
                 + {2'b00, (r_cap1 == r_cap4)} + {2'b00, (r_cap2 == r_cap3)}
                 + {2'b00, (r_cap2 == r_cap4)} + {2'b00, (r_cap3 == r_cap4)};
    w_is_jackpot = 1'b0;
    w_payout     = 14'd0;
    case (w_match_cnt)
      3'd6: begin
        if (r_cap1 == 4'd7) begin
          w_is_jackpot = 1'b1;
          w_payout     = c_pay_jackpot;
        end else begin
          w_payout     = c_pay_four;
        end
      end
      3'd3:    w_payout = c_pay_three;
      3'd2:    w_payout = c_pay_two_pair;
      3'd1:    w_payout = c_pay_pair;
      default: w_payout = 14'd0;
    endcase
    // A 15-bit sum cannot wrap, so the ceiling compare is exact
    w_sum       = {1'b0, r_score} + {1'b0, w_payout};
    w_new_score = (w_sum > c_max_score) ? c_max_score[13:0] : w_sum[13:0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: new_game overrides everything and discards pending work
  always_comb begin
    w_state_nxt = r_state;
    if (new_game) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_spin_rise && (r_score >= c_bet)) w_state_nxt = S_SPIN;
        S_SPIN: if (w_to_rise)                         w_state_nxt = S_EVAL;
        S_EVAL: w_state_nxt = S_PAY;
        S_PAY:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Bank datapath: bet charge, reel capture and payout; the payout is
  // registered on leaving EVAL so it is visible for exactly the PAY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score     <= c_start_score;
      r_last_win  <= 14'd0;
      r_win_valid <= 1'b0;
      r_jackpot   <= 1'b0;
      r_cap1      <= 4'd0;
      r_cap2      <= 4'd0;
      r_cap3      <= 4'd0;
      r_cap4      <= 4'd0;
    end else begin
      r_win_valid <= 1'b0;
      if (new_game) begin
        r_score    <= c_start_score;
        r_last_win <= 14'd0;
        r_jackpot  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_spin_rise && (r_score >= c_bet)) begin
              r_score   <= r_score - c_bet;
              r_jackpot <= 1'b0;
            end
          end
          S_SPIN: begin
            if (w_to_rise) begin
              r_cap1 <= reel1;
              r_cap2 <= reel2;
              r_cap3 <= reel3;
              r_cap4 <= reel4;
            end
          end
          S_EVAL: begin
            r_score     <= w_new_score;
            r_last_win  <= w_payout;
            r_win_valid <= 1'b1;
            if (w_is_jackpot) r_jackpot <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign score     = r_score;
  assign is_broke  = (r_score < c_bet);
  assign last_win  = r_last_win;
  assign win_valid = r_win_valid;
  assign jackpot   = r_jackpot;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Brief    : Self-checking bench for score_keeper against a digit-histogram
//             reference model of the bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

  localparam int c_start = 100;
  localparam int c_bet   = 10;
  localparam int c_max   = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spinning = 1'b0;
  logic        to_score = 1'b0;
  logic        new_game = 1'b0;
  logic [3:0]  reel1 = 4'd0;
  logic [3:0]  reel2 = 4'd0;
  logic [3:0]  reel3 = 4'd0;
  logic [3:0]  reel4 = 4'd0;
  logic [13:0] score;
  logic        is_broke;
  logic [13:0] last_win;
  logic        win_valid;
  logic        jackpot;

  int n_checks = 0;
  int n_pass   = 0;
  int m_score  = c_start;
  int m_last   = 0;
  int m_jack   = 0;

  score_keeper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spinning  (spinning),
    .to_score  (to_score),
    .new_game  (new_game),
    .reel1     (reel1),
    .reel2     (reel2),
    .reel3     (reel3),
    .reel4     (reel4),
    .score     (score),
    .is_broke  (is_broke),
    .last_win  (last_win),
    .win_valid (win_valid),
    .jackpot   (jackpot)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference payout from a histogram of the four digits
  function automatic int ref_payout(input int a, input int b, input int c, input int d);
    int cnt[10];
    int mx, pairs;
    foreach (cnt[i]) cnt[i] = 0;
    cnt[a]++; cnt[b]++; cnt[c]++; cnt[d]++;
    mx = 0; pairs = 0;
    foreach (cnt[i]) begin
      if (cnt[i] > mx) mx = cnt[i];
      if (cnt[i] == 2) pairs++;
    end
    if (mx == 4)      return (a == 7) ? 1000 : 500;
    if (mx == 3)      return 100;
    if (pairs == 2)   return 50;
    if (pairs == 1)   return 20;
    return 0;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_score"}, 32'(score), m_score);
    check_eq({tag, "_broke"}, 32'(is_broke), (m_score < c_bet) ? 1 : 0);
    check_eq({tag, "_jack"},  32'(jackpot), m_jack);
  endtask

  // Raise spinning; bet lands on the third edge if credit allows
  task automatic bet_phase(output bit ok);
    @(negedge clk) spinning = 1'b1;
    ok = (m_score >= c_bet);
    repeat (2) @(posedge clk);
    #1 check_eq("pre_bet_score", 32'(score), m_score);
    @(posedge clk);
    #1;
    if (ok) begin
      m_score -= c_bet;
      m_jack   = 0;
    end
    check_outputs("bet");
  endtask

  // Raise to_score with given reels; payout visible after the fourth edge
  task automatic score_phase(input int a, input int b, input int c, input int d, input bit expect_win);
    int p;
    @(negedge clk);
    reel1 = 4'(a); reel2 = 4'(b); reel3 = 4'(c); reel4 = 4'(d);
    to_score = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 4 && expect_win) begin
        p = ref_payout(a, b, c, d);
        m_score = (m_score + p > c_max) ? c_max : m_score + p;
        m_last  = p;
        if (p == 1000) m_jack = 1;
        check_eq("win_valid", 32'(win_valid), 1);
        check_eq("last_win", 32'(last_win), m_last);
        check_outputs("pay");
      end else begin
        check_eq("win_quiet", 32'(win_valid), 0);
      end
    end
    check_eq("post_score", 32'(score), m_score);
  endtask

  task automatic drop_inputs();
    @(negedge clk);
    spinning = 1'b0;
    to_score = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic spin(input int a, input int b, input int c, input int d);
    bit ok;
    bet_phase(ok);
    score_phase(a, b, c, d, ok);
    drop_inputs();
  endtask

  task automatic pulse_new_game();
    @(negedge clk) new_game = 1'b1;
    @(posedge clk);
    #1;
    m_score = c_start; m_jack = 0; m_last = 0;
    check_outputs("new_game");
    check_eq("ng_last", 32'(last_win), 0);
    @(negedge clk) new_game = 1'b0;
  endtask

  initial begin
    bit ok;
    int a, b, c, d;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check_eq("reset_last", 32'(last_win), 0);
    check_eq("reset_wv", 32'(win_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed payout classes
    spin(3, 5, 3, 8);
    spin(2, 2, 6, 6);
    spin(4, 4, 4, 1);
    spin(9, 9, 9, 9);
    spin(7, 7, 7, 7);
    spin(0, 1, 2, 3);   // bet clears jackpot, zero payout still pulses

    // Exact-bet boundary and broke behaviour
    pulse_new_game();
    repeat (9) spin(0, 1, 2, 3);
    spin(5, 6, 8, 9);   // 10 -> 0
    spin(7, 7, 7, 7);   // refused bet, no win

    // Saturation via repeated jackpots
    pulse_new_game();
    repeat (10) spin(7, 7, 7, 7);

    // Same-cycle rise of spinning and to_score in IDLE
    pulse_new_game();
    @(negedge clk);
    reel1 = 4'd7; reel2 = 4'd7; reel3 = 4'd7; reel4 = 4'd7;
    spinning = 1'b1; to_score = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_score -= c_bet;
    check_outputs("same_bet");
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1 check_eq("same_quiet", 32'(win_valid), 0);
    end
    @(negedge clk) to_score = 1'b0;
    repeat (4) @(posedge clk);
    score_phase(7, 7, 7, 7, 1'b1);
    drop_inputs();

    // new_game while waiting in SPIN discards the round
    bet_phase(ok);
    pulse_new_game();
    score_phase(7, 7, 7, 7, 1'b0);
    drop_inputs();

    // Randomized rounds
    for (int n = 0; n < 30; n++) begin
      a = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        b = a; c = a; d = ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, 9);
      end else begin
        b = $urandom_range(0, 9); c = $urandom_range(0, 9); d = $urandom_range(0, 9);
      end
      spin(a, b, c, d);
    end

    // Reset asserted during PAY
    pulse_new_game();
    bet_phase(ok);
    @(negedge clk);
    reel1 = 4'd3; reel2 = 4'd5; reel3 = 4'd3; reel4 = 4'd8;
    to_score = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_eq("pay_wv", 32'(win_valid), 1);
    rst_n = 1'b0;
    #1;
    m_score = c_start; m_jack = 0;
    check_outputs("mid_rst");
    check_eq("mid_rst_last", 32'(last_win), 0);
    check_eq("mid_rst_wv", 32'(win_valid), 0);
    spinning = 1'b0; to_score = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check_outputs("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
